// File: rtl/fetch_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_sequencer_pkg
//  Description : Shared types and constants for the fetch sequencer: address
//                width, jump opcode and the fetch state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_sequencer_pkg;

    localparam int ADDR_W = 8;

    // Opcode that the fetch stage consumes itself (unconditional jump)
    localparam logic [1:0] OP_JUMP = 2'b11;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2,
        HALT  = 2'd3
    } fetch_state_t;

    // Increment that sticks at the all-ones value instead of wrapping
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_sequencer_pc_register.sv
`default_nettype none
// ============================================================================
//  Module      : pc_register
//  Description : Program counter. Load has priority over increment; when
//                neither load nor advance is requested the value is held.
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_register
    import fetch_sequencer_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              hold_i,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] load_addr_i,
    output logic [ADDR_W-1:0] pc_o
);

    logic [ADDR_W-1:0] pc_q;

    // PC update: reset, then load, then increment unless held (wraps naturally)
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= '0;
        end else if (load_i) begin
            pc_q <= load_addr_i;
        end else if (!hold_i) begin
            pc_q <= pc_q + ADDR_W'(1);
        end
    end

    assign pc_o = pc_q;

endmodule
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_sequencer
//  Description : Program-counter and fetch controller. Resolves jumps in
//                fetch, honours hazard stalls and execute redirects, fills
//                the IF/ID register and halts at END_ADDR.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter logic [ADDR_W-1:0] END_ADDR    = 8'd7,
    // Boot idle cycles; only the low 8 bits are used by the boot counter
    parameter int unsigned       BOOT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_address,
    input  logic [1:0]        opcode,
    input  logic [ADDR_W-1:0] jump_address,
    output logic [ADDR_W-1:0] instruction_address,
    output logic              if_id_valid,
    output logic [ADDR_W-1:0] if_id_pc,
    output logic              halted,
    output logic [7:0]        fetch_count
);

    localparam logic [7:0] BOOT_LIMIT = BOOT_CYCLES[7:0];

    fetch_state_t      state_q, state_d;
    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] ifid_pc_q, ifid_pc_d;
    logic              halted_q, halted_d;
    logic [7:0]        count_q, count_d;
    logic [7:0]        boot_q, boot_d;

    logic              pc_hold;
    logic              pc_load;
    logic [ADDR_W-1:0] pc_target;
    logic [ADDR_W-1:0] pc;

    pc_register u_pc (
        .clk         (clk),
        .reset       (reset),
        .hold_i      (pc_hold),
        .load_i      (pc_load),
        .load_addr_i (pc_target),
        .pc_o        (pc)
    );

    // Next-state, next-PC selection and IF/ID update in priority order
    always_comb begin
        state_d   = state_q;
        valid_d   = valid_q;
        ifid_pc_d = ifid_pc_q;
        count_d   = count_q;
        boot_d    = boot_q;
        pc_hold   = 1'b1;
        pc_load   = 1'b0;
        pc_target = '0;

        unique case (state_q)
            BOOT: begin
                // Instruction memory settles here; PC stays at 0
                valid_d = 1'b0;
                boot_d  = boot_q + 8'd1;
                if ((boot_q + 8'd1) >= BOOT_LIMIT) begin
                    state_d = RUN;
                end
            end
            RUN, STALL: begin
                if (redirect) begin
                    // Late redirect wins over everything, including stall
                    pc_load   = 1'b1;
                    pc_target = redirect_address;
                    valid_d   = 1'b0;
                    state_d   = RUN;
                end else if (stall) begin
                    state_d = STALL;
                end else if (pc == END_ADDR) begin
                    // END_ADDR itself is never delivered
                    valid_d = 1'b0;
                    state_d = HALT;
                end else if (opcode == OP_JUMP) begin
                    // Jump is consumed here and leaves a bubble behind it
                    pc_load   = 1'b1;
                    pc_target = jump_address;
                    valid_d   = 1'b0;
                    state_d   = RUN;
                end else begin
                    valid_d   = 1'b1;
                    ifid_pc_d = pc;
                    pc_hold   = 1'b0;
                    count_d   = sat_inc8(count_q);
                    state_d   = RUN;
                end
            end
            HALT: begin
                valid_d = 1'b0;
            end
            default: begin
                state_d = BOOT;
            end
        endcase

        halted_d = (state_d == HALT);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= BOOT;
            valid_q   <= 1'b0;
            ifid_pc_q <= '0;
            halted_q  <= 1'b0;
            count_q   <= 8'd0;
            boot_q    <= 8'd0;
        end else begin
            state_q   <= state_d;
            valid_q   <= valid_d;
            ifid_pc_q <= ifid_pc_d;
            halted_q  <= halted_d;
            count_q   <= count_d;
            boot_q    <= boot_d;
        end
    end

    assign instruction_address = pc;
    assign if_id_valid         = valid_q;
    assign if_id_pc            = ifid_pc_q;
    assign halted              = halted_q;
    assign fetch_count         = count_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_sequencer
//  Description : Directed bench for fetch_sequencer. Two instances share the
//                control inputs: A halts at 8'h07, B at 8'hFF. Each has its
//                own view of a common instruction memory.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_sequencer;

    typedef struct {
        logic [1:0] st;
        logic [7:0] pc;
        logic       v;
        logic [7:0] ipc;
        logic       h;
        logic [7:0] cnt;
        logic [7:0] boot;
    } ms_t;

    typedef struct {
        ms_t a;
        ms_t b;
    } pair_t;

    localparam logic [1:0] M_BOOT = 2'd0, M_RUN = 2'd1, M_STALL = 2'd2, M_HALT = 2'd3;
    localparam int TB_BOOT_CYCLES = 1;

    logic       clk = 1'b0;
    logic       reset;
    logic       stall;
    logic       redirect;
    logic [7:0] redirect_address;

    logic [1:0] mem_op [256];
    logic [7:0] mem_ja [256];

    logic [7:0] a_addr, a_ipc, a_cnt, a_ja;
    logic       a_v, a_h;
    logic [1:0] a_op;
    logic [7:0] b_addr, b_ipc, b_cnt, b_ja;
    logic       b_v, b_h;
    logic [1:0] b_op;

    int vectors     = 0;
    int miscompares = 0;

    ms_t   ma, mb;
    pair_t exp_q [$];

    always #5 clk = ~clk;

    assign a_op = mem_op[a_addr];
    assign a_ja = mem_ja[a_addr];
    assign b_op = mem_op[b_addr];
    assign b_ja = mem_ja[b_addr];

    fetch_sequencer #(.END_ADDR(8'h07), .BOOT_CYCLES(TB_BOOT_CYCLES)) dut_a (
        .clk                 (clk),
        .reset               (reset),
        .stall               (stall),
        .redirect            (redirect),
        .redirect_address    (redirect_address),
        .opcode              (a_op),
        .jump_address        (a_ja),
        .instruction_address (a_addr),
        .if_id_valid         (a_v),
        .if_id_pc            (a_ipc),
        .halted              (a_h),
        .fetch_count         (a_cnt)
    );

    fetch_sequencer #(.END_ADDR(8'hFF), .BOOT_CYCLES(TB_BOOT_CYCLES)) dut_b (
        .clk                 (clk),
        .reset               (reset),
        .stall               (stall),
        .redirect            (redirect),
        .redirect_address    (redirect_address),
        .opcode              (b_op),
        .jump_address        (b_ja),
        .instruction_address (b_addr),
        .if_id_valid         (b_v),
        .if_id_pc            (b_ipc),
        .halted              (b_h),
        .fetch_count         (b_cnt)
    );

    // Reference behaviour for one clock edge
    function automatic ms_t mnext(input ms_t s, input logic rst, input logic stl,
                                  input logic rd, input logic [7:0] ra,
                                  input logic [7:0] end_addr);
        ms_t n;
        n = s;
        if (rst) begin
            n.st = M_BOOT; n.pc = 8'd0; n.v = 1'b0; n.ipc = 8'd0;
            n.h = 1'b0; n.cnt = 8'd0; n.boot = 8'd0;
        end else begin
            case (s.st)
                M_BOOT: begin
                    n.v = 1'b0;
                    n.boot = s.boot + 8'd1;
                    if (int'(n.boot) >= TB_BOOT_CYCLES) n.st = M_RUN;
                end
                M_RUN, M_STALL: begin
                    if (rd) begin
                        n.pc = ra; n.v = 1'b0; n.st = M_RUN;
                    end else if (stl) begin
                        n.st = M_STALL;
                    end else if (s.pc == end_addr) begin
                        n.v = 1'b0; n.st = M_HALT;
                    end else if (mem_op[s.pc] == 2'b11) begin
                        n.pc = mem_ja[s.pc]; n.v = 1'b0; n.st = M_RUN;
                    end else begin
                        n.v = 1'b1; n.ipc = s.pc; n.pc = s.pc + 8'd1;
                        if (s.cnt != 8'hFF) n.cnt = s.cnt + 8'd1;
                        n.st = M_RUN;
                    end
                end
                default: n.v = 1'b0;
            endcase
            n.h = (n.st == M_HALT);
        end
        return n;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic chk_dut(input string n, input ms_t e, input logic [7:0] addr,
                           input logic v, input logic [7:0] ipc, input logic h,
                           input logic [7:0] cnt);
        chk({n, ".instruction_address"}, addr, e.pc);
        chk({n, ".if_id_valid"}, {7'd0, v}, {7'd0, e.v});
        if (e.v) chk({n, ".if_id_pc"}, ipc, e.ipc);
        chk({n, ".halted"}, {7'd0, h}, {7'd0, e.h});
        chk({n, ".fetch_count"}, cnt, e.cnt);
    endtask

    // Drive one cycle of inputs, queue the expectation, check after the edge
    task automatic step(input logic rst, input logic stl, input logic rd,
                        input logic [7:0] ra);
        pair_t e;
        reset = rst; stall = stl; redirect = rd; redirect_address = ra;
        e.a = mnext(ma, rst, stl, rd, ra, 8'h07);
        e.b = mnext(mb, rst, stl, rd, ra, 8'hFF);
        exp_q.push_back(e);
        ma = e.a;
        mb = e.b;
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk_dut("A", e.a, a_addr, a_v, a_ipc, a_h, a_cnt);
        chk_dut("B", e.b, b_addr, b_v, b_ipc, b_h, b_cnt);
        chk("A.end_addr_delivered", {7'd0, (a_v === 1'b1 && a_ipc === 8'h07)}, 8'd0);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        ma = '{default: '0};
        mb = '{default: '0};
        for (int i = 0; i < 256; i++) begin
            mem_op[i] = 2'(i % 3);
            mem_ja[i] = 8'h00;
        end
        mem_op[8'h04] = 2'b11; mem_ja[8'h04] = 8'h05;  // plain forward jump
        mem_op[8'h30] = 2'b11; mem_ja[8'h30] = 8'h07;  // jump onto END_ADDR of A
        mem_op[8'h40] = 2'b11; mem_ja[8'h40] = 8'h40;  // self-jump
        mem_op[8'h2F] = 2'b11; mem_ja[8'h2F] = 8'h20;  // loop 0x20..0x2F

        // Reset, boot, first fetches
        step(1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        chk("reset.pc", a_addr, 8'h00);
        chk("reset.count", a_cnt, 8'h00);
        run(3);
        chk("boot.first_fetch_pc", a_ipc, 8'h01);

        // Stall 3 cycles at PC 2, then release
        step(1'b0, 1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b1, 1'b0, 8'h00);
        run(1);

        // Redirect together with stall at PC 3
        step(1'b0, 1'b1, 1'b1, 8'h00);

        // Run through the jump at PC 4 into HALT at 7 (A)
        run(12);
        chk("halt.A_halted", {7'd0, a_h}, 8'd1);

        // Stall and redirect are ignored while halted
        step(1'b0, 1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b1, 8'h02);
        run(2);

        // Reset; redirect during BOOT is ignored; jump onto END_ADDR
        step(1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b1, 8'h55);
        step(1'b0, 1'b0, 1'b1, 8'h30);
        run(4);

        // Reset; redirect onto END_ADDR
        step(1'b1, 1'b0, 1'b0, 8'h00);
        run(1);
        step(1'b0, 1'b0, 1'b1, 8'h07);
        run(3);

        // Self-jump keeps IF/ID empty
        step(1'b0, 1'b0, 1'b1, 8'h40);
        run(5);

        // Long loop to saturate fetch_count on B
        step(1'b0, 1'b0, 1'b1, 8'h20);
        run(340);
        chk("sat.B_count", b_cnt, 8'hFF);

        // Halt at the top of the address space on B
        step(1'b0, 1'b0, 1'b1, 8'hFE);
        run(4);
        chk("wrap.B_halted", {7'd0, b_h}, 8'd1);

        // Reset clears halted and fetch_count
        step(1'b1, 1'b0, 1'b0, 8'h00);
        chk("final_reset.B_count", b_cnt, 8'h00);
        chk("final_reset.B_halted", {7'd0, b_h}, 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_sequencer.md
# fetch_sequencer

Program-counter and fetch controller for the 8-bit pipelined core. Drives `instruction_address` into `instruction_fetch`, takes back the decoded `opcode` and `jump_address` in the same cycle, and writes the IF/ID pipeline register. It resolves unconditional jumps in fetch, applies stalls from the hazard unit, takes late redirects from execute, and halts at a programmable end address.

## Interface
Parameters:
- `END_ADDR`, default 8'd7: the block halts when the PC reaches this address, and does not fetch it.
- `BOOT_CYCLES`, default 1: idle cycles after reset release. Instruction memory is loaded while `reset` is high and settles during these cycles.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `stall`  in  1  from the hazard unit. Holds the PC and IF/ID.
- `redirect`  in  1  execute-stage redirect request.
- `redirect_address`  in  8  new PC when `redirect` is 1.
- `opcode`  in  2  opcode of the instruction at the current PC, from `instruction_fetch`.
- `jump_address`  in  8  jump target at the current PC, from `instruction_fetch`.
- `instruction_address`  out  8  current PC.
- `if_id_valid`  out  1  IF/ID register holds a live instruction.
- `if_id_pc`  out  8  PC of the instruction held in IF/ID.
- `halted`  out  1  the block is in HALT.
- `fetch_count`  out  8  count of instructions delivered into IF/ID. Saturates at 255.

## Operation
- The state machine has four states: BOOT, RUN, STALL, HALT.
- Reset values: state BOOT, PC 0, `if_id_valid` 0, `if_id_pc` 0, `halted` 0, `fetch_count` 0, boot counter 0.
- **BOOT**
  - The PC is held at 0 and IF/ID is invalid.
  - The boot counter increments each cycle. When it reaches `BOOT_CYCLES`, the next state is RUN.
- **RUN and STALL** share one priority order, highest first:
  1. **redirect**:
     - PC <= `redirect_address`.
     - `if_id_valid` <= 0, which flushes the wrong-path slot.
     - This applies even when `stall` is 1.
     - Next state is RUN.
  2. **stall**:
     - PC and IF/ID are held and `fetch_count` is held.
     - Next state is STALL.
  3. **PC == END_ADDR**:
     - `if_id_valid` <= 0 and next state is HALT.
  4. **opcode == 2'b11 (jump)**:
     - PC <= `jump_address`.
     - `if_id_valid` <= 0. The jump is consumed in fetch and is never passed down the pipe.
  5. **Otherwise**:
     - IF/ID <= {valid=1, pc=PC}.
     - PC <= PC+1, with 8-bit wrap from 255 to 0.
     - `fetch_count` increments.
- STALL behaves exactly as RUN and returns to RUN on the first cycle where `stall` is 0.
- **HALT**
  - `halted` is 1, `if_id_valid` is 0 and the PC is frozen.
  - Only reset leaves HALT. `redirect` and `stall` are ignored.
- **Width and arithmetic rules**
  - Jump targets are `{PC[7:6], instr[5:0]}`, formed upstream, so jumps stay within the current 64-word page.
  - `fetch_count` saturates and does not wrap.
- **Boundary conditions**
  - A jump whose target equals END_ADDR halts on the following cycle without delivering anything.
  - A redirect to END_ADDR behaves the same way.
  - A self-jump loops forever with `if_id_valid` at 0, and no watchdog is required.
  - A redirect while in BOOT is ignored.
  - Reset asserted in any state returns to the reset values at the next edge.

## Timing
- All outputs are registered except `instruction_address`, which is the PC register driven directly.
- The fetch-to-IF/ID latency is 1 cycle: the instruction at PC N appears with `if_id_pc`=N at the next edge.
- The jump penalty is one bubble cycle, meaning `if_id_valid` is 0 for the cycle after the jump is seen.
- The redirect penalty is one flushed slot, and the new PC is presented on the cycle after `redirect`.
- `stall` is sampled at the clock edge. A stall of k cycles freezes IF/ID for exactly k cycles.
- `halted` rises on the edge after the PC reaches END_ADDR.

## Structure
- A shared package holds:
  - opcode constants, including `OP_JUMP` = 2'b11;
  - the state encoding `fetch_state_t` (BOOT, RUN, STALL, HALT);
  - `ADDR_W` = 8.
- One sub-module, `pc_register`: 8-bit PC with synchronous reset, hold enable and load port.
- The next-PC selection and the state machine live in `fetch_sequencer`.

## Test plan
- **Reset and boot:** reset for 2 cycles, then release with BOOT_CYCLES=1 → PC stays 0 for 1 cycle; next cycle IF/ID = {1, 0}, PC = 1, `fetch_count`=1.
- **Jump in fetch:** opcode 11 at PC 4 with jump_address 8'h05 → PC becomes 5, `if_id_valid`=0 for one cycle, and the PC-4 jump never appears in IF/ID.
- **Stall:** `stall` high for 3 cycles at PC 2 → PC stays 2 and IF/ID stays {1, 1} for 3 cycles; next cycle IF/ID = {1, 2}.
- **Redirect beats stall:** `redirect`=1 with address 8'h00 while `stall`=1 at PC 3 → PC=0, `if_id_valid`=0, state RUN.
- **Halt:** run with END_ADDR=7 → `halted`=1 after PC reaches 7 and address 7 never appears in IF/ID; later stall/redirect have no effect, and reset clears `halted` and `fetch_count`.
- **Saturation and wrap:** END_ADDR=8'hFF with a redirect to 8'hFE → the PC wraps from 0xFF to 0x00 is not reached, and HALT occurs at 0xFF; a separate run of 300 fetches keeps `fetch_count` at 255.
